key_sched_ctrl: RTL and testbench

AES-128 key-schedule sequencer sitting directly downstream of `GenKey` and feeding the cipher datapath. On `start` it captures the cipher key and drives the single-round `GenKey` stage ten times. Each pass supplies the previous round key and the correct `Rcon`, and the block stores each returned round key. The resulting 11-entry round-key file (keys 0–10) is exposed to the round datapath through a registered read port.

---
 rtl/aes_pkg.sv | 38 +++
 rtl/round_key_file.sv | 55 +++++
 rtl/key_sched_ctrl.sv | 148 ++++++++++++++
 tb/tb_key_sched_ctrl.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/aes_pkg.sv
// ---------------------------------------------------------------------------
// aes_pkg
// Shared definitions for the AES-128 key-schedule sequencer:
//   KEY_LEN / WORD_LEN / NUM_ROUNDS  - key, Rcon word and round-count sizes
//   RK_DEPTH / RK_AW                 - round-key file depth and index width
//   RCON                             - rc byte for rounds 1..NUM_ROUNDS
//   ks_state_e                       - sequencer FSM states
//   rcon_word()                      - {rc, 24'h0} for a 1-based round number
// ---------------------------------------------------------------------------
package aes_pkg;

  localparam int KEY_LEN    = 128;
  localparam int WORD_LEN   = 32;
  localparam int NUM_ROUNDS = 10;
  localparam int RK_DEPTH   = NUM_ROUNDS + 1;
  localparam int RK_AW      = 4;

  localparam logic [7:0] RCON [NUM_ROUNDS] = '{
    8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
    8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
  };

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    DONE
  } ks_state_e;

  // Round numbers are 1-based; anything outside 1..NUM_ROUNDS yields zero.
  function automatic logic [WORD_LEN-1:0] rcon_word(input logic [RK_AW-1:0] rnd);
    rcon_word = '0;
    if (rnd >= RK_AW'(1) && rnd <= RK_AW'(NUM_ROUNDS)) begin
      rcon_word = {RCON[rnd - RK_AW'(1)], {(WORD_LEN - 8){1'b0}}};
    end
  endfunction

endpackage

// File: rtl/round_key_file.sv
// ---------------------------------------------------------------------------
// round_key_file
// RK_DEPTH x KEY_LEN register file holding round keys 0..NUM_ROUNDS.
//   clk, reset       - rising-edge clock, synchronous active-high clear
//   wr_en/wr_addr/wr_data - synchronous write port
//   rd_addr          - read index; out-of-range indices read as zero
//   rd_key           - registered read data (one-cycle latency)
// A read of an entry in its write cycle returns the old contents.
// ---------------------------------------------------------------------------
module round_key_file
  import aes_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic               wr_en,
  input  logic [RK_AW-1:0]   wr_addr,
  input  logic [KEY_LEN-1:0] wr_data,
  input  logic [RK_AW-1:0]   rd_addr,
  output logic [KEY_LEN-1:0] rd_key
);

  logic [KEY_LEN-1:0] rk_q [RK_DEPTH];
  logic [KEY_LEN-1:0] rk_d [RK_DEPTH];
  logic [KEY_LEN-1:0] rd_key_q;
  logic [KEY_LEN-1:0] rd_key_d;

  always_comb begin
    rk_d = rk_q;
    if (wr_en && wr_addr <= RK_AW'(NUM_ROUNDS)) begin
      rk_d[wr_addr] = wr_data;
    end
    // Reading rk_q (not rk_d) gives old-data behaviour on a same-cycle write.
    rd_key_d = '0;
    if (rd_addr <= RK_AW'(NUM_ROUNDS)) begin
      rd_key_d = rk_q[rd_addr];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      // NOTE: this storage is flop-based and must read zero after reset, so
      // every entry is cleared explicitly; a RAM macro could not do this.
      for (int i = 0; i < RK_DEPTH; i++) begin
        rk_q[i] <= '0;
      end
      rd_key_q <= '0;
    end else begin
      rk_q     <= rk_d;
      rd_key_q <= rd_key_d;
    end
  end

  assign rd_key = rd_key_q;

endmodule

// File: rtl/key_sched_ctrl.sv
// ---------------------------------------------------------------------------
// key_sched_ctrl
// AES-128 key-schedule sequencer. On start it stores key_in as round key 0,
// then drives the external single-round GenKey stage NUM_ROUNDS times, each
// time presenting the previous round key and the round's Rcon word, and
// stores every returned key in the round-key file.
//   clk, reset      - rising-edge clock, synchronous active-high reset
//   start, key_in   - begin expansion (accepted only when idle)
//   busy            - expansion in progress (ISSUE/WAIT/DONE)
//   done            - one-cycle pulse when all round keys are stored
//   keys_valid      - level, round-key file complete
//   gk_valid_in, gk_key_in, gk_rcon    - request to GenKey
//   gk_round_key, gk_valid_out         - result from GenKey
//   rd_addr, rd_key - registered round-key read port
// All outputs are registered.
// ---------------------------------------------------------------------------
module key_sched_ctrl
  import aes_pkg::*;
(
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic [KEY_LEN-1:0]  key_in,
  output logic                busy,
  output logic                done,
  output logic                keys_valid,
  output logic                gk_valid_in,
  output logic [KEY_LEN-1:0]  gk_key_in,
  output logic [WORD_LEN-1:0] gk_rcon,
  input  logic [KEY_LEN-1:0]  gk_round_key,
  input  logic                gk_valid_out,
  input  logic [RK_AW-1:0]    rd_addr,
  output logic [KEY_LEN-1:0]  rd_key
);

  ks_state_e            state_q, state_d;
  logic [RK_AW-1:0]     round_q, round_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic                 keys_valid_q, keys_valid_d;
  logic                 gk_valid_in_q, gk_valid_in_d;
  logic [KEY_LEN-1:0]   gk_key_in_q, gk_key_in_d;
  logic [WORD_LEN-1:0]  gk_rcon_q, gk_rcon_d;

  logic                 wr_en;
  logic [RK_AW-1:0]     wr_addr;
  logic [KEY_LEN-1:0]   wr_data;

  always_comb begin
    // NOTE: every signal assigned here gets a default first, so no path
    // leaves one unassigned and no latch is inferred.
    state_d      = state_q;
    round_d      = round_q;
    keys_valid_d = keys_valid_q;
    gk_key_in_d  = gk_key_in_q;
    gk_rcon_d    = gk_rcon_q;
    wr_en        = 1'b0;
    wr_addr      = '0;
    wr_data      = '0;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          wr_en        = 1'b1;
          wr_addr      = '0;
          wr_data      = key_in;
          round_d      = RK_AW'(1);
          keys_valid_d = 1'b0;
          // The previous round key for round 1 is the cipher key itself, so
          // it is presented directly rather than read back from the file.
          gk_key_in_d  = key_in;
          gk_rcon_d    = rcon_word(RK_AW'(1));
          state_d      = ISSUE;
        end
      end
      ISSUE: begin
        state_d = WAIT;
      end
      WAIT: begin
        if (gk_valid_out) begin
          wr_en   = 1'b1;
          wr_addr = round_q;
          wr_data = gk_round_key;
          if (round_q == RK_AW'(NUM_ROUNDS)) begin
            state_d = DONE;
          end else begin
            round_d     = round_q + RK_AW'(1);
            gk_key_in_d = gk_round_key;
            gk_rcon_d   = rcon_word(round_q + RK_AW'(1));
            state_d     = ISSUE;
          end
        end
      end
      DONE: begin
        keys_valid_d = 1'b1;
        state_d      = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Outputs are decoded from the next state so they line up with it.
    busy_d        = (state_d != IDLE);
    done_d        = (state_d == DONE);
    gk_valid_in_d = (state_d == ISSUE);
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    if (reset) begin
      state_q       <= IDLE;
      round_q       <= '0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      keys_valid_q  <= 1'b0;
      gk_valid_in_q <= 1'b0;
      gk_key_in_q   <= '0;
      gk_rcon_q     <= '0;
    end else begin
      state_q       <= state_d;
      round_q       <= round_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      keys_valid_q  <= keys_valid_d;
      gk_valid_in_q <= gk_valid_in_d;
      gk_key_in_q   <= gk_key_in_d;
      gk_rcon_q     <= gk_rcon_d;
    end
  end

  round_key_file u_rk_file (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .rd_addr (rd_addr),
    .rd_key  (rd_key)
  );

  assign busy        = busy_q;
  assign done        = done_q;
  assign keys_valid  = keys_valid_q;
  assign gk_valid_in = gk_valid_in_q;
  assign gk_key_in   = gk_key_in_q;
  assign gk_rcon     = gk_rcon_q;

endmodule

// File: tb/tb_key_sched_ctrl.sv
// ---------------------------------------------------------------------------
// tb_key_sched_ctrl
// Directed bench for key_sched_ctrl with a behavioural GenKey responder of
// fixed latency GK_LAT. Expected round keys are the FIPS-197 values.
// ---------------------------------------------------------------------------
module tb_key_sched_ctrl;
  import aes_pkg::*;

  localparam int GK_LAT = 3;

  localparam logic [127:0] K_FIPS   = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] K_FIPS1  = 128'ha0fafe1788542cb123a339392a6c7605;
  localparam logic [127:0] K_FIPS2  = 128'hf2c295f27a96b9435935807a7359f67f;
  localparam logic [127:0] K_FIPS10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
  localparam logic [127:0] K_B      = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] K_B1     = 128'hd6aa74fdd2af72fadaa678f1d6ab76fe;
  localparam logic [127:0] K_B10    = 128'h13111d7fe3944a17f307a78b4d2b30c5;
  localparam logic [127:0] K_ALT    = 128'hdeadbeef0123456789abcdeffeedface;

  logic [7:0] exp_rc [10] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
                              8'h20, 8'h40, 8'h80, 8'h1b, 8'h36};

  logic [7:0] sbox [256] = '{
    8'h63,8'h7c,8'h77,8'h7b,8'hf2,8'h6b,8'h6f,8'hc5,8'h30,8'h01,8'h67,8'h2b,8'hfe,8'hd7,8'hab,8'h76,
    8'hca,8'h82,8'hc9,8'h7d,8'hfa,8'h59,8'h47,8'hf0,8'had,8'hd4,8'ha2,8'haf,8'h9c,8'ha4,8'h72,8'hc0,
    8'hb7,8'hfd,8'h93,8'h26,8'h36,8'h3f,8'hf7,8'hcc,8'h34,8'ha5,8'he5,8'hf1,8'h71,8'hd8,8'h31,8'h15,
    8'h04,8'hc7,8'h23,8'hc3,8'h18,8'h96,8'h05,8'h9a,8'h07,8'h12,8'h80,8'he2,8'heb,8'h27,8'hb2,8'h75,
    8'h09,8'h83,8'h2c,8'h1a,8'h1b,8'h6e,8'h5a,8'ha0,8'h52,8'h3b,8'hd6,8'hb3,8'h29,8'he3,8'h2f,8'h84,
    8'h53,8'hd1,8'h00,8'hed,8'h20,8'hfc,8'hb1,8'h5b,8'h6a,8'hcb,8'hbe,8'h39,8'h4a,8'h4c,8'h58,8'hcf,
    8'hd0,8'hef,8'haa,8'hfb,8'h43,8'h4d,8'h33,8'h85,8'h45,8'hf9,8'h02,8'h7f,8'h50,8'h3c,8'h9f,8'ha8,
    8'h51,8'ha3,8'h40,8'h8f,8'h92,8'h9d,8'h38,8'hf5,8'hbc,8'hb6,8'hda,8'h21,8'h10,8'hff,8'hf3,8'hd2,
    8'hcd,8'h0c,8'h13,8'hec,8'h5f,8'h97,8'h44,8'h17,8'hc4,8'ha7,8'h7e,8'h3d,8'h64,8'h5d,8'h19,8'h73,
    8'h60,8'h81,8'h4f,8'hdc,8'h22,8'h2a,8'h90,8'h88,8'h46,8'hee,8'hb8,8'h14,8'hde,8'h5e,8'h0b,8'hdb,
    8'he0,8'h32,8'h3a,8'h0a,8'h49,8'h06,8'h24,8'h5c,8'hc2,8'hd3,8'hac,8'h62,8'h91,8'h95,8'he4,8'h79,
    8'he7,8'hc8,8'h37,8'h6d,8'h8d,8'hd5,8'h4e,8'ha9,8'h6c,8'h56,8'hf4,8'hea,8'h65,8'h7a,8'hae,8'h08,
    8'hba,8'h78,8'h25,8'h2e,8'h1c,8'ha6,8'hb4,8'hc6,8'he8,8'hdd,8'h74,8'h1f,8'h4b,8'hbd,8'h8b,8'h8a,
    8'h70,8'h3e,8'hb5,8'h66,8'h48,8'h03,8'hf6,8'h0e,8'h61,8'h35,8'h57,8'hb9,8'h86,8'hc1,8'h1d,8'h9e,
    8'he1,8'hf8,8'h98,8'h11,8'h69,8'hd9,8'h8e,8'h94,8'h9b,8'h1e,8'h87,8'he9,8'hce,8'h55,8'h28,8'hdf,
    8'h8c,8'ha1,8'h89,8'h0d,8'hbf,8'he6,8'h42,8'h68,8'h41,8'h99,8'h2d,8'h0f,8'hb0,8'h54,8'hbb,8'h16
  };

  logic                clk = 1'b0;
  logic                reset = 1'b1;
  logic                start = 1'b0;
  logic [KEY_LEN-1:0]  key_in = '0;
  logic                busy, done, keys_valid, gk_valid_in;
  logic [KEY_LEN-1:0]  gk_key_in;
  logic [WORD_LEN-1:0] gk_rcon;
  logic [KEY_LEN-1:0]  gk_round_key = '0;
  logic                gk_valid_out = 1'b0;
  logic [RK_AW-1:0]    rd_addr = '0;
  logic [KEY_LEN-1:0]  rd_key;

  key_sched_ctrl dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .key_in       (key_in),
    .busy         (busy),
    .done         (done),
    .keys_valid   (keys_valid),
    .gk_valid_in  (gk_valid_in),
    .gk_key_in    (gk_key_in),
    .gk_rcon      (gk_rcon),
    .gk_round_key (gk_round_key),
    .gk_valid_out (gk_valid_out),
    .rd_addr      (rd_addr),
    .rd_key       (rd_key)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [KEY_LEN-1:0] obs,
                       input logic [KEY_LEN-1:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, want %h", tag, obs, exp);
    end
  endtask

  // One AES-128 key-expansion round, as GenKey computes it.
  function automatic logic [127:0] gen_key(input logic [127:0] k, input logic [31:0] rc);
    logic [31:0] w0, w1, w2, w3, t, n0, n1, n2, n3;
    w0 = k[127:96]; w1 = k[95:64]; w2 = k[63:32]; w3 = k[31:0];
    t  = {sbox[w3[23:16]], sbox[w3[15:8]], sbox[w3[7:0]], sbox[w3[31:24]]} ^ rc;
    n0 = w0 ^ t; n1 = w1 ^ n0; n2 = w2 ^ n1; n3 = w3 ^ n2;
    return {n0, n1, n2, n3};
  endfunction

  // GenKey responder: answers each request GK_LAT cycles later; stray_req
  // injects an unsolicited strobe. Also logs Rcon per request and counts done.
  int                gk_cnt = 0;
  logic [127:0]      gk_res = '0;
  logic              stray_req = 1'b0;
  logic [127:0]      stray_key = '0;
  logic [31:0]       rcon_log [$];
  int                done_cnt = 0;

  always @(negedge clk) begin
    gk_valid_out = 1'b0;
    if (stray_req) begin
      gk_valid_out = 1'b1;
      gk_round_key = stray_key;
    end
    if (gk_cnt > 0) begin
      gk_cnt--;
      if (gk_cnt == 0) begin
        gk_valid_out = 1'b1;
        gk_round_key = gk_res;
      end
    end
    if (gk_valid_in) begin
      gk_res = gen_key(gk_key_in, gk_rcon);
      gk_cnt = GK_LAT;
      rcon_log.push_back(gk_rcon);
    end
    if (done) done_cnt++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input logic [127:0] k);
    start  = 1'b1;
    key_in = k;
    tick();
    start  = 1'b0;
  endtask

  task automatic wait_done(output int cycles);
    cycles = 0;
    while (done !== 1'b1 && cycles < 500) begin
      tick();
      cycles++;
    end
    if (done !== 1'b1) check("done_timeout", 128'(done), 128'd1);
  endtask

  task automatic wait_issues(input int n);
    int c = 0;
    while (rcon_log.size() < n && c < 500) begin
      tick();
      c++;
    end
    if (rcon_log.size() < n) check("issue_timeout", 128'(rcon_log.size()), 128'(n));
  endtask

  task automatic read_key(input logic [RK_AW-1:0] addr, output logic [127:0] data);
    rd_addr = addr;
    tick();
    data = rd_key;
  endtask

  initial begin
    int            cyc;
    int            d0;
    logic [127:0]  rk;

    // Reset state
    tick(); tick();
    check("rst_busy",        128'(busy),        128'd0);
    check("rst_done",        128'(done),        128'd0);
    check("rst_keys_valid",  128'(keys_valid),  128'd0);
    check("rst_gk_valid_in", 128'(gk_valid_in), 128'd0);
    check("rst_gk_key_in",   gk_key_in,         128'd0);
    check("rst_gk_rcon",     128'(gk_rcon),     128'd0);
    check("rst_rd_key",      rd_key,            128'd0);
    reset = 1'b0;
    tick();
    read_key(4'd1, rk); check("rst_rk1", rk, 128'd0);

    // Full FIPS-197 expansion with Rcon sequencing
    rcon_log.delete();
    d0 = done_cnt;
    do_start(K_FIPS);
    check("fips_busy_start", 128'(busy), 128'd1);
    wait_done(cyc);
    check("fips_latency",    128'(cyc),  128'(10 * (1 + GK_LAT)));
    check("fips_busy_done",  128'(busy), 128'd1);
    tick();
    check("fips_done_pulse", 128'(done),       128'd0);
    check("fips_busy_after", 128'(busy),       128'd0);
    check("fips_keys_valid", 128'(keys_valid), 128'd1);
    check("fips_done_count", 128'(done_cnt - d0), 128'd1);
    check("rcon_count", 128'(rcon_log.size()), 128'd10);
    for (int i = 0; i < 10; i++) begin
      if (i < rcon_log.size()) check($sformatf("rcon_%0d", i + 1), 128'(rcon_log[i]), 128'({exp_rc[i], 24'h0}));
      else                     check($sformatf("rcon_%0d", i + 1), 128'd0,              128'({exp_rc[i], 24'h0}));
    end
    read_key(4'd0,  rk); check("fips_rk0",  rk, K_FIPS);
    read_key(4'd1,  rk); check("fips_rk1",  rk, K_FIPS1);
    read_key(4'd2,  rk); check("fips_rk2",  rk, K_FIPS2);
    read_key(4'd10, rk); check("fips_rk10", rk, K_FIPS10);

    // Start while busy (during round 5) is ignored
    rcon_log.delete();
    do_start(K_FIPS);
    check("swb_keys_valid_clr", 128'(keys_valid), 128'd0);
    wait_issues(5);
    start = 1'b1; key_in = K_ALT;
    tick();
    start = 1'b0;
    check("swb_busy", 128'(busy), 128'd1);
    wait_done(cyc);
    tick();
    check("swb_rcon_count", 128'(rcon_log.size()), 128'd10);
    read_key(4'd10, rk); check("swb_rk10", rk, K_FIPS10);
    read_key(4'd0,  rk); check("swb_rk0",  rk, K_FIPS);

    // Stray GenKey strobe in IDLE, then read-port boundaries
    stray_key = '1;
    stray_req = 1'b1;
    tick();
    stray_req = 1'b0;
    tick();
    check("stray_busy",        128'(busy),        128'd0);
    check("stray_gk_valid_in", 128'(gk_valid_in), 128'd0);
    check("stray_keys_valid",  128'(keys_valid),  128'd1);
    read_key(4'd10, rk); check("stray_rk10", rk, K_FIPS10);
    read_key(4'd0,  rk); check("rd_addr0",   rk, K_FIPS);
    read_key(4'd15, rk); check("rd_addr15",  rk, 128'd0);
    read_key(4'd11, rk); check("rd_addr11",  rk, 128'd0);

    // Back-to-back start in the cycle after done; read-during-write on rk[0]
    do_start(K_FIPS);
    wait_done(cyc);
    tick();
    check("b2b_busy_low", 128'(busy), 128'd0);
    start = 1'b1; key_in = K_B; rd_addr = 4'd0;
    tick();
    start = 1'b0;
    check("b2b_rd_old",      rd_key,           K_FIPS);
    check("b2b_keys_valid",  128'(keys_valid), 128'd0);
    check("b2b_busy",        128'(busy),       128'd1);
    tick();
    check("b2b_rd_new",      rd_key,           K_B);
    wait_done(cyc);
    tick();
    read_key(4'd1,  rk); check("b2b_rk1",  rk, K_B1);
    read_key(4'd10, rk); check("b2b_rk10", rk, K_B10);

    // Reset during round 3 with a GenKey result still outstanding
    rcon_log.delete();
    do_start(K_FIPS);
    wait_issues(3);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("mid_rst_busy",       128'(busy),        128'd0);
    check("mid_rst_keys_valid", 128'(keys_valid),  128'd0);
    check("mid_rst_gk_valid",   128'(gk_valid_in), 128'd0);
    check("mid_rst_gk_rcon",    128'(gk_rcon),     128'd0);
    read_key(4'd1, rk); check("mid_rst_rk1", rk, 128'd0);
    tick(); tick(); tick(); tick();
    read_key(4'd3, rk); check("mid_rst_late_rk3", rk, 128'd0);
    read_key(4'd2, rk); check("mid_rst_rk2",      rk, 128'd0);
    check("mid_rst_idle", 128'(busy), 128'd0);
    do_start(K_B);
    wait_done(cyc);
    tick();
    check("mid_rst_keys_valid_end", 128'(keys_valid), 128'd1);
    read_key(4'd10, rk); check("mid_rst_rk10", rk, K_B10);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
